c4_move_scheduler: RTL

//  Conditions the three raw player buttons (sync, debounce, press-edge) and schedules the

---
 rtl/c4_pkg.sv | 50 +++++
 rtl/c4_btn_conditioner.sv | 57 +++++
 rtl/c4_move_scheduler.sv | 139 +++++++++++++
 3 files changed

// File: rtl/c4_pkg.sv
// ----------------------------------------------------------------------------
// c4_pkg
//  Shared definitions for the Connect Four front end.
//  - VGA timing constants used by the top level and the move scheduler.
//  - State enum for the move scheduler FSM.
//  - Command vector type {drop, left, right} plus helpers that decide which
//    command to issue from a set of pending requests.
// ----------------------------------------------------------------------------
package c4_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int V_TOTAL  = 525;

  typedef enum logic {
    IDLE,
    ISSUE
  } state_t;

  // Bit order matches the external pending port: {drop, left, right}.
  typedef struct packed {
    logic drop;
    logic left;
    logic right;
  } cmd_t;

  // Command to pulse for a given pending set. Drop wins; left and right
  // together cancel each other and produce nothing.
  function automatic cmd_t issue_cmd(input cmd_t p);
    cmd_t c;
    c = '0;
    if (p.drop)                  c.drop  = 1'b1;
    else if (p.left && !p.right) c.left  = 1'b1;
    else if (p.right && !p.left) c.right = 1'b1;
    return c;
  endfunction

  // Pending bits consumed by an issue slot. Identical to the issued command,
  // except a left/right conflict consumes both requests.
  function automatic cmd_t clear_cmd(input cmd_t p);
    cmd_t c;
    c = issue_cmd(p);
    if (!p.drop && p.left && p.right) begin
      c.left  = 1'b1;
      c.right = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/c4_btn_conditioner.sv
// ----------------------------------------------------------------------------
// c4_btn_conditioner
//  One raw push button -> one-cycle press pulse.
//  2-FF synchronizer, then a debouncer that only accepts a new level after it
//  has differed from the accepted level for DEBOUNCE_CYCLES consecutive
//  cycles, then rising-edge detect on the accepted level.
// Ports
//  clk    in  1  system clock
//  rst_n  in  1  synchronous active-low reset
//  btn    in  1  raw asynchronous button, active-high
//  press  out 1  registered one-cycle pulse when the debounced level rises
// ----------------------------------------------------------------------------
module c4_btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             deb_q;
  logic [CNT_W-1:0] cnt_q;

  // NOTE: all state updates use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; a blocking '=' here would collapse
  // the two synchronizer stages into one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      deb_q  <= 1'b0;
      cnt_q  <= '0;
      press  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};
      press  <= 1'b0;
      if (sync_q[1] != deb_q) begin
        if (cnt_q == CNT_LAST) begin
          deb_q <= sync_q[1];
          cnt_q <= '0;
          // Accepting a new high level is the press edge; releases give none.
          press <= sync_q[1];
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        // Any bounce back to the accepted level restarts the qualification.
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/c4_move_scheduler.sv
// ----------------------------------------------------------------------------
// c4_move_scheduler
//  Conditions the three player buttons and turns presses into sticky pending
//  requests, then issues at most one command pulse per video frame, in the
//  cycle right after vertical blanking starts, so the board never changes
//  during scan-out. After a drop no command is issued for DROP_HOLDOFF frames.
// Ports
//  clk_25MHz   in  1   pixel/system clock
//  rst_n       in  1   synchronous active-low reset
//  btn_right   in  1   raw button, asynchronous, active-high
//  btn_left    in  1   raw button, asynchronous, active-high
//  btn_drop    in  1   raw button, asynchronous, active-high
//  v_count     in  10  line counter from vga_controller
//  game_over   in  1   blocks and flushes all requests while high
//  move_right  out 1   one-cycle command pulse
//  move_left   out 1   one-cycle command pulse
//  drop_piece  out 1   one-cycle command pulse
//  pending     out 3   {drop,left,right} requests not yet issued
// ----------------------------------------------------------------------------
module c4_move_scheduler #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DROP_HOLDOFF    = 2,
  parameter int V_ACTIVE        = c4_pkg::V_ACTIVE
) (
  input  logic       clk_25MHz,
  input  logic       rst_n,
  input  logic       btn_right,
  input  logic       btn_left,
  input  logic       btn_drop,
  input  logic [9:0] v_count,
  input  logic       game_over,
  output logic       move_right,
  output logic       move_left,
  output logic       drop_piece,
  output logic [2:0] pending
);

  import c4_pkg::*;

  localparam int HOLD_W = (DROP_HOLDOFF > 0) ? $clog2(DROP_HOLDOFF + 1) : 1;

  logic press_right, press_left, press_drop;
  cmd_t press;

  c4_btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_right (
    .clk   (clk_25MHz),
    .rst_n (rst_n),
    .btn   (btn_right),
    .press (press_right)
  );

  c4_btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_left (
    .clk   (clk_25MHz),
    .rst_n (rst_n),
    .btn   (btn_left),
    .press (press_left)
  );

  c4_btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_drop (
    .clk   (clk_25MHz),
    .rst_n (rst_n),
    .btn   (btn_drop),
    .press (press_drop)
  );

  assign press = {press_drop, press_left, press_right};

  state_t            state;
  cmd_t              pend_q;
  cmd_t              clear_q;
  logic [HOLD_W-1:0] holdoff_q;
  logic [9:0]        v_prev_q;
  logic              vblank_start;
  cmd_t              next_issue;
  cmd_t              next_clear;

  // Single-cycle strobe on the first cycle of the blanking line.
  assign vblank_start = (v_count == 10'(V_ACTIVE)) && (v_prev_q != 10'(V_ACTIVE));

  assign next_issue = issue_cmd(pend_q);
  assign next_clear = clear_cmd(pend_q);

  assign pending = pend_q;

  // NOTE: reset is synchronous, so it only takes effect on a clock edge; every
  // register in this block is cleared there, including the hold-off count, so
  // a reset during a hold-off leaves nothing blocking the next command.
  always_ff @(posedge clk_25MHz) begin
    if (!rst_n) begin
      state      <= IDLE;
      pend_q     <= '0;
      clear_q    <= '0;
      holdoff_q  <= '0;
      v_prev_q   <= '0;
      move_right <= 1'b0;
      move_left  <= 1'b0;
      drop_piece <= 1'b0;
    end else begin
      v_prev_q   <= v_count;
      move_right <= 1'b0;
      move_left  <= 1'b0;
      drop_piece <= 1'b0;

      case (state)
        IDLE: begin
          if (vblank_start) begin
            if ((pend_q != '0) && (holdoff_q == '0) && !game_over) begin
              // The command is chosen here and registered, so its pulse is
              // high exactly during the ISSUE cycle.
              move_right <= next_issue.right;
              move_left  <= next_issue.left;
              drop_piece <= next_issue.drop;
              clear_q    <= next_clear;
              state      <= ISSUE;
            end else if (holdoff_q != '0) begin
              holdoff_q <= holdoff_q - 1'b1;
            end
          end
        end
        ISSUE: begin
          if (clear_q.drop) holdoff_q <= HOLD_W'(DROP_HOLDOFF);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Pending requests: consumed bits clear at the end of ISSUE, but a new
      // press of the same button in that cycle wins and stays queued.
      if (game_over) begin
        pend_q <= '0;
      end else if (state == ISSUE) begin
        pend_q <= (pend_q & ~clear_q) | press;
      end else begin
        pend_q <= pend_q | press;
      end
    end
  end

endmodule
